gf463_accum_feeder: RTL and testbench

Streaming accumulator directly upstream of the combinational Barrett reducer for p = 463. It accepts a frame of 9-bit residues over a valid/ready handshake and sums them into a 17-bit raw total. It presents that total as a registered, held output whose data bus connects straight to the reducer's 17-bit `din_a`. The reducer's 9-bit `dout_r` is then the frame sum mod 463.

---
 rtl/gf463_pkg.sv | 22 ++
 rtl/gf463_accum_feeder_if.sv | 34 +++
 rtl/gf463_accum_feeder.sv | 105 ++++++++++
 tb/tb_gf463_accum_feeder.sv | 246 ++++++++++++++++++++++++
 4 files changed

// File: rtl/gf463_pkg.sv
`default_nettype none
// ============================================================================
// Module      : gf463_pkg
// Description : Shared constants and state encoding for the GF(463) datapath.
// Revision    : 1.0 - initial release
// ============================================================================
package gf463_pkg;

  localparam int unsigned P         = 463;
  localparam int unsigned DATA_W    = 9;
  localparam int unsigned SUM_W     = 17;
  localparam int unsigned MAX_TERMS = 256;
  // Wide enough to hold MAX_TERMS itself, not just MAX_TERMS-1.
  localparam int unsigned COUNT_W   = 9;

  typedef enum logic [0:0] {
    ST_ACCUM = 1'b0,
    ST_HOLD  = 1'b1
  } feeder_state_e;

endpackage : gf463_pkg
`default_nettype wire

// File: rtl/gf463_accum_feeder_if.sv
`default_nettype none
// ============================================================================
// Module      : gf463_accum_feeder_if
// Description : Input beat stream and held frame-sum output of the feeder.
// Revision    : 1.0 - initial release
// ============================================================================
interface gf463_accum_feeder_if;
  import gf463_pkg::*;

  logic                in_valid;
  logic                in_ready;
  logic [DATA_W-1:0]   in_data;
  logic                in_last;
  logic                out_valid;
  logic                out_ready;
  logic [SUM_W-1:0]    out_data;
  logic [COUNT_W-1:0]  out_count;
  logic                out_trunc;
  logic                err;

  // Producer of beats / consumer of sums.
  modport master (
    output in_valid, in_data, in_last, out_ready,
    input  in_ready, out_valid, out_data, out_count, out_trunc, err
  );

  // The accumulator block itself.
  modport slave (
    input  in_valid, in_data, in_last, out_ready,
    output in_ready, out_valid, out_data, out_count, out_trunc, err
  );

endinterface : gf463_accum_feeder_if
`default_nettype wire

// File: rtl/gf463_accum_feeder.sv
`default_nettype none
// ============================================================================
// Module      : gf463_accum_feeder
// Description : Sums a frame of 9-bit residues into a held 17-bit raw total
//               that feeds the p = 463 Barrett reducer input directly.
// Revision    : 1.0 - initial release
// ============================================================================
module gf463_accum_feeder
  import gf463_pkg::*;
(
  input  logic                 clk,
  input  logic                 rst_n,
  gf463_accum_feeder_if.slave  bus
);

  localparam logic [0:0] S_ACCUM = ST_ACCUM;
  localparam logic [0:0] S_HOLD  = ST_HOLD;

  localparam logic [COUNT_W-1:0] c_max_terms = COUNT_W'(MAX_TERMS);
  localparam logic [DATA_W-1:0]  c_p         = DATA_W'(P);
  localparam logic [COUNT_W-1:0] c_one       = COUNT_W'(1);

  logic [0:0]          r_state;
  logic [SUM_W-1:0]    r_sum;
  logic [COUNT_W-1:0]  r_count;
  logic                r_out_valid;
  logic [SUM_W-1:0]    r_out_data;
  logic [COUNT_W-1:0]  r_out_count;
  logic                r_out_trunc;
  logic                r_err;

  logic                w_in_ready;
  logic                w_accept;
  logic                w_close;
  logic                w_out_hs;
  logic [SUM_W-1:0]    w_sum_next;
  logic [COUNT_W-1:0]  w_count_next;

  always_comb begin
    w_in_ready   = (r_state == S_ACCUM);
    w_accept     = bus.in_valid && w_in_ready;
    w_sum_next   = r_sum + SUM_W'(bus.in_data);
    w_count_next = r_count + c_one;
    // A frame closes on in_last or when the beat limit is reached.
    w_close      = w_accept && (bus.in_last || (w_count_next == c_max_terms));
    w_out_hs     = r_out_valid && bus.out_ready;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= S_ACCUM;
      r_sum       <= '0;
      r_count     <= '0;
      r_out_valid <= 1'b0;
      r_out_data  <= '0;
      r_out_count <= '0;
      r_out_trunc <= 1'b0;
    end else begin
      case (r_state)
        S_ACCUM: begin
          if (w_close) begin
            r_out_data  <= w_sum_next;
            r_out_count <= w_count_next;
            r_out_trunc <= !bus.in_last;
            r_out_valid <= 1'b1;
            r_sum       <= '0;
            r_count     <= '0;
            r_state     <= S_HOLD;
          end else if (w_accept) begin
            r_sum   <= w_sum_next;
            r_count <= w_count_next;
          end
        end
        S_HOLD: begin
          if (w_out_hs) begin
            r_out_valid <= 1'b0;
            r_state     <= S_ACCUM;
          end
        end
        default: begin
          r_out_valid <= 1'b0;
          r_state     <= S_ACCUM;
        end
      endcase
    end
  end

  // Out-of-range residues are still summed; the flag only records them.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_err <= 1'b0;
    end else if (w_accept && (bus.in_data >= c_p)) begin
      r_err <= 1'b1;
    end
  end

  assign bus.in_ready  = w_in_ready;
  assign bus.out_valid = r_out_valid;
  assign bus.out_data  = r_out_data;
  assign bus.out_count = r_out_count;
  assign bus.out_trunc = r_out_trunc;
  assign bus.err       = r_err;

endmodule : gf463_accum_feeder
`default_nettype wire

// File: tb/tb_gf463_accum_feeder.sv
`default_nettype none
// ============================================================================
// Module      : tb_gf463_accum_feeder
// Description : Self-checking bench for the GF(463) frame accumulator.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_gf463_accum_feeder;
  import gf463_pkg::*;

  logic clk = 1'b0;
  logic rst_n = 1'b0;

  gf463_accum_feeder_if bus();

  gf463_accum_feeder dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  int n_chk  = 0;
  int n_fail = 0;
  int cyc    = 0;

  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    int n;
    int d [4];
    int exp_sum;
    int exp_cnt;
    int exp_red;
  } vec_t;

  vec_t tbl [5];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  task automatic set_vec(input int i, input int n, input int d0, input int d1,
                         input int d2, input int d3, input int s, input int c, input int r);
    tbl[i].n = n;
    tbl[i].d[0] = d0; tbl[i].d[1] = d1; tbl[i].d[2] = d2; tbl[i].d[3] = d3;
    tbl[i].exp_sum = s; tbl[i].exp_cnt = c; tbl[i].exp_red = r;
  endtask

  // Called at a negedge; returns at the negedge after the beat was accepted.
  task automatic beat(input int d, input bit l);
    int w;
    logic [31:0] dv;
    w  = 0;
    dv = d;
    bus.in_valid = 1'b1;
    bus.in_data  = dv[8:0];
    bus.in_last  = l;
    while (!bus.in_ready && w < 1000) begin
      @(negedge clk);
      w++;
    end
    if (w >= 1000) chk("beat_timeout", 32'd0, 32'd1);
    @(posedge clk);
    @(negedge clk);
    bus.in_valid = 1'b0;
    bus.in_last  = 1'b0;
  endtask

  task automatic check_out(input string nm, input int s, input int c, input bit t, input int r);
    chk({nm, "_valid"}, bus.out_valid, 1);
    chk({nm, "_data"},  bus.out_data, s);
    chk({nm, "_count"}, bus.out_count, c);
    chk({nm, "_trunc"}, bus.out_trunc, t);
    chk({nm, "_reduced"}, bus.out_data % 463, r);
    chk({nm, "_in_ready_low"}, bus.in_ready, 0);
  endtask

  task automatic release_out(input string nm);
    bus.out_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    chk({nm, "_valid_drop"}, bus.out_valid, 0);
    chk({nm, "_ready_back"}, bus.in_ready, 1);
    bus.out_ready = 1'b0;
  endtask

  localparam int NFR = 1000;

  int q_sum [$];
  int q_cnt [$];
  int sent_beats, got_beats, got, lim, len, s, es, ec;
  int dv [256];
  bit acc;

  initial begin
    bus.in_valid  = 1'b0;
    bus.in_data   = '0;
    bus.in_last   = 1'b0;
    bus.out_ready = 1'b0;

    set_vec(0, 3, 100, 200, 300, 0,  600, 3, 137);
    set_vec(1, 1,   1,   0,   0, 0,    1, 1,   1);
    set_vec(2, 2,   0,   0,   0, 0,    0, 2,   0);
    set_vec(3, 4, 462, 462, 462, 462, 1848, 4, 459);
    set_vec(4, 2, 250, 212,   0, 0,  462, 2, 462);

    // Reset values while held in reset.
    repeat (3) @(negedge clk);
    chk("rst_in_ready",  bus.in_ready, 1);
    chk("rst_out_valid", bus.out_valid, 0);
    chk("rst_out_data",  bus.out_data, 0);
    chk("rst_out_count", bus.out_count, 0);
    chk("rst_out_trunc", bus.out_trunc, 0);
    chk("rst_err",       bus.err, 0);
    rst_n = 1'b1;
    @(negedge clk);

    for (int i = 0; i < 5; i++) begin
      for (int b = 0; b < tbl[i].n; b++) beat(tbl[i].d[b], b == tbl[i].n - 1);
      check_out($sformatf("vec%0d", i), tbl[i].exp_sum, tbl[i].exp_cnt, 1'b0, tbl[i].exp_red);
      chk($sformatf("vec%0d_err", i), bus.err, 0);
      release_out($sformatf("vec%0d", i));
    end

    // Output held while the consumer stalls.
    beat(462, 1'b1);
    for (int i = 0; i < 5; i++) begin
      chk("hold_valid", bus.out_valid, 1);
      chk("hold_data", bus.out_data, 462);
      chk("hold_count", bus.out_count, 1);
      chk("hold_in_ready", bus.in_ready, 0);
      @(negedge clk);
    end
    release_out("hold");

    // Frame closed by the beat limit.
    for (int i = 0; i < 256; i++) beat(462, 1'b0);
    check_out("trunc", 118272, 256, 1'b1, 207);
    release_out("trunc");

    // Limit beat that also carries in_last is a normal close.
    for (int i = 0; i < 256; i++) beat(1, i == 255);
    check_out("full_last", 256, 256, 1'b0, 256);
    release_out("full_last");

    // Out-of-range value is flagged, still summed, and the flag is sticky.
    beat(500, 1'b0);
    beat(10, 1'b1);
    check_out("err", 510, 2, 1'b0, 47);
    chk("err_set", bus.err, 1);
    release_out("err");
    beat(7, 1'b1);
    check_out("err_clean", 7, 1, 1'b0, 7);
    chk("err_sticky", bus.err, 1);

    // Reset while in HOLD drops out_valid without a clock edge.
    #1 rst_n = 1'b0;
    #1;
    chk("rst_hold_valid", bus.out_valid, 0);
    chk("rst_hold_ready", bus.in_ready, 1);
    chk("rst_hold_err", bus.err, 0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    // Reset mid-frame discards the partial sum.
    beat(40, 1'b0);
    beat(50, 1'b0);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    beat(5, 1'b1);
    check_out("rst_mid", 5, 1, 1'b0, 5);
    chk("rst_mid_err", bus.err, 0);
    release_out("rst_mid");

    // Randomised handshakes on both sides.
    sent_beats = 0;
    got_beats  = 0;
    got        = 0;
    lim        = cyc + 80000;
    fork
      begin : drv
        for (int f = 0; f < NFR; f++) begin
          len = (f % 100 == 99) ? int'($urandom_range(1, 256)) : int'($urandom_range(1, 8));
          s = 0;
          for (int b = 0; b < len; b++) begin
            dv[b] = int'($urandom_range(0, 511));
            s += dv[b];
          end
          q_sum.push_back(s);
          q_cnt.push_back(len);
          for (int b = 0; b < len; b++) begin
            acc = 1'b0;
            while (!acc && cyc < lim) begin
              @(negedge clk);
              bus.in_valid = ($urandom_range(0, 3) != 0);
              bus.in_data  = dv[b][8:0];
              bus.in_last  = (b == len - 1);
              acc = bus.in_valid && bus.in_ready;
            end
            if (acc) sent_beats++;
          end
        end
        @(negedge clk);
        bus.in_valid = 1'b0;
        bus.in_last  = 1'b0;
      end
      begin : mon
        while (got < NFR && cyc < lim) begin
          @(negedge clk);
          chk("ready_valid_excl", bus.in_ready && bus.out_valid, 0);
          bus.out_ready = ($urandom_range(0, 2) != 0);
          if (bus.out_valid && bus.out_ready) begin
            if (q_sum.size() == 0) begin
              chk("rand_unexpected_frame", 1, 0);
            end else begin
              es = q_sum.pop_front();
              ec = q_cnt.pop_front();
              chk("rand_sum", bus.out_data, es);
              chk("rand_count", bus.out_count, ec);
              chk("rand_trunc", bus.out_trunc, 0);
            end
            got_beats += int'(bus.out_count);
            got++;
          end
        end
        bus.out_ready = 1'b0;
        if (got < NFR) chk("rand_timeout", got, NFR);
      end
    join
    chk("rand_beats_total", got_beats, sent_beats);
    chk("rand_queue_empty", q_sum.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule : tb_gf463_accum_feeder
`default_nettype wire
